// File: rtl/dcache_snoop_responder.sv
// Snoop responder for one dcache on a two-core MSI bus: looks up snooped
// blocks, flushes Modified data, and downgrades or invalidates the line.
// Optional statistics counters are enabled by defining SNOOP_STATS_EN.
module dcache_snoop_responder #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 2,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned OFF_W = $clog2(WORDS),
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ccwait,
  input  logic                  ccinv,
  input  logic [31:0]           ccsnoopaddr,
  input  logic                  dwait,
  input  logic [WAYS*TAG_W-1:0] tag_rd,
  input  logic [WAYS*2-1:0]     st_rd,
  input  logic [31:0]           data_rd,
  output logic [IDX_W-1:0]      snp_idx,
  output logic [1:0]            rd_way,
  output logic [OFF_W-1:0]      rd_off,
  output logic                  ccwrite,
  output logic [31:0]           dstore,
  output logic                  upd_en,
  output logic [1:0]            upd_way,
  output logic [1:0]            upd_state,
`ifdef SNOOP_STATS_EN
  output logic [15:0]           snp_hits,
  output logic [15:0]           snp_flushes,
`endif
  output logic                  cpu_hold
);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, FLUSH, UPDATE, DONE} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   snp_tag_q, snp_tag_d;
  logic [IDX_W-1:0]   snp_idx_q, snp_idx_d;
  logic               inv_q, inv_d;
  logic               hit_q, hit_d;
  logic [1:0]         hit_way_q, hit_way_d;
  logic [1:0]         hit_st_q, hit_st_d;
  logic [1:0]         rd_way_q, rd_way_d;
  logic [OFF_W-1:0]   rd_off_q, rd_off_d;
  logic               ccwrite_q, ccwrite_d;
  logic               upd_en_q, upd_en_d;
  logic [1:0]         upd_way_q, upd_way_d;
  logic [1:0]         upd_state_q, upd_state_d;

  logic               hit_c;
  logic [1:0]         hit_way_c;
  logic [1:0]         hit_st_c;
  logic               last_word_c;

  // Byte and word offset of the snooped address do not affect the lookup.
  logic unused_addr;
  assign unused_addr = ^ccsnoopaddr[1+OFF_W:0];

  // Tag compare across ways; the lowest-numbered valid matching way wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = 2'b00;
    hit_st_c  = ST_I;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_c && st_rd[2*w +: 2] != ST_I && tag_rd[TAG_W*w +: TAG_W] == snp_tag_q) begin
        hit_c     = 1'b1;
        hit_way_c = 2'(w);
        hit_st_c  = st_rd[2*w +: 2];
      end
    end
  end

  assign last_word_c = (rd_off_q == OFF_W'(WORDS - 1));

  // Next-state and registered-output logic for the snoop sequence.
  always_comb begin
    state_d     = state_q;
    snp_tag_d   = snp_tag_q;
    snp_idx_d   = snp_idx_q;
    inv_d       = inv_q;
    hit_d       = hit_q;
    hit_way_d   = hit_way_q;
    hit_st_d    = hit_st_q;
    rd_way_d    = rd_way_q;
    rd_off_d    = rd_off_q;
    ccwrite_d   = ccwrite_q;
    upd_en_d    = 1'b0;
    upd_way_d   = 2'b00;
    upd_state_d = ST_I;

    if (state_q != IDLE && ccwait && ccinv) inv_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (ccwait) begin
          snp_tag_d = ccsnoopaddr[31 -: TAG_W];
          snp_idx_d = ccsnoopaddr[2+OFF_W +: IDX_W];
          inv_d     = 1'b0;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!ccwait) begin
          state_d = IDLE;
        end else begin
          hit_d     = hit_c;
          hit_way_d = hit_way_c;
          hit_st_d  = hit_st_c;
          rd_way_d  = hit_way_c;
          ccwrite_d = hit_c && (hit_st_c == ST_M);
          state_d   = RESP;
        end
      end
      RESP: begin
        if (!ccwait) begin
          state_d = IDLE;
        end else if (hit_q && hit_st_q == ST_M) begin
          rd_off_d = '0;
          state_d  = FLUSH;
        end else if (hit_q) begin
          state_d = UPDATE;
        end else begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        if (!ccwait) begin
          state_d = IDLE;
        end else if (!dwait) begin
          if (last_word_c) state_d = UPDATE;
          else             rd_off_d = rd_off_q + OFF_W'(1);
        end
      end
      UPDATE: begin
        // The strobe is issued even if ccwait drops during this cycle.
        upd_en_d    = 1'b1;
        upd_way_d   = hit_way_q;
        upd_state_d = (inv_q || (ccwait && ccinv)) ? ST_I : ST_S;
        state_d     = DONE;
      end
      DONE: begin
        if (!ccwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      ccwrite_d = 1'b0;
      rd_off_d  = '0;
      rd_way_d  = 2'b00;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      snp_tag_q   <= '0;
      snp_idx_q   <= '0;
      inv_q       <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= 2'b00;
      hit_st_q    <= ST_I;
      rd_way_q    <= 2'b00;
      rd_off_q    <= '0;
      ccwrite_q   <= 1'b0;
      upd_en_q    <= 1'b0;
      upd_way_q   <= 2'b00;
      upd_state_q <= ST_I;
    end else begin
      state_q     <= state_d;
      snp_tag_q   <= snp_tag_d;
      snp_idx_q   <= snp_idx_d;
      inv_q       <= inv_d;
      hit_q       <= hit_d;
      hit_way_q   <= hit_way_d;
      hit_st_q    <= hit_st_d;
      rd_way_q    <= rd_way_d;
      rd_off_q    <= rd_off_d;
      ccwrite_q   <= ccwrite_d;
      upd_en_q    <= upd_en_d;
      upd_way_q   <= upd_way_d;
      upd_state_q <= upd_state_d;
    end
  end

  assign snp_idx   = snp_idx_q;
  assign rd_way    = rd_way_q;
  assign rd_off    = rd_off_q;
  assign ccwrite   = ccwrite_q;
  assign upd_en    = upd_en_q;
  assign upd_way   = upd_way_q;
  assign upd_state = upd_state_q;
  // dstore passes the array word straight through so the word accepted on
  // dwait=0 is always the one addressed by rd_off.
  assign dstore    = (state_q == FLUSH) ? data_rd : 32'd0;
  assign cpu_hold  = ccwait | (state_q != IDLE);

`ifdef SNOOP_STATS_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] flushes_q, flushes_d;
  logic        flush_done_c;

  assign flush_done_c = (state_q == FLUSH) && ccwait && !dwait && last_word_c;

  // Saturating hit and completed-flush counters.
  always_comb begin
    hits_d    = hits_q;
    flushes_d = flushes_q;
    if (state_q == RESP && hit_q && hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
    if (flush_done_c && flushes_q != 16'hFFFF) flushes_d = flushes_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hits_q    <= 16'd0;
      flushes_q <= 16'd0;
    end else begin
      hits_q    <= hits_d;
      flushes_q <= flushes_d;
    end
  end

  assign snp_hits    = hits_q;
  assign snp_flushes = flushes_q;
`else
  // Statistics disabled: no counters.
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Directed bench for dcache_snoop_responder with a scoreboard of expected
// flush words and state updates.
module tb_dcache_snoop_responder;

  localparam int unsigned SETS  = 8;
  localparam int unsigned WAYS  = 2;
  localparam int unsigned WORDS = 2;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned OFF_W = 1;
  localparam int unsigned TAG_W = 26;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  ccwait, ccinv, dwait;
  logic [31:0]           ccsnoopaddr;
  logic [WAYS*TAG_W-1:0] tag_rd;
  logic [WAYS*2-1:0]     st_rd;
  logic [31:0]           data_rd;
  logic [IDX_W-1:0]      snp_idx;
  logic [1:0]            rd_way;
  logic [OFF_W-1:0]      rd_off;
  logic                  ccwrite;
  logic [31:0]           dstore;
  logic                  upd_en;
  logic [1:0]            upd_way, upd_state;
  logic                  cpu_hold;
`ifdef SNOOP_STATS_EN
  logic [15:0]           snp_hits, snp_flushes;
`endif

  dcache_snoop_responder #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .tag_rd(tag_rd),
    .st_rd(st_rd), .data_rd(data_rd), .snp_idx(snp_idx), .rd_way(rd_way),
    .rd_off(rd_off), .ccwrite(ccwrite), .dstore(dstore), .upd_en(upd_en),
    .upd_way(upd_way), .upd_state(upd_state),
`ifdef SNOOP_STATS_EN
    .snp_hits(snp_hits), .snp_flushes(snp_flushes),
`endif
    .cpu_hold(cpu_hold)
  );

  always #5 CLK = ~CLK;

  // Cache array model
  logic [TAG_W-1:0] tags [SETS][4];
  logic [1:0]       sts  [SETS][4];

  function automatic logic [31:0] word_of(input int w, input int s, input int o);
    return 32'hD000_0000 | 32'(w << 16) | 32'(s << 8) | 32'(o);
  endfunction

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t,
                                          input logic [IDX_W-1:0] i,
                                          input logic [OFF_W-1:0] o);
    return {t, i, o, 2'b00};
  endfunction

  always_comb begin
    tag_rd = '0;
    st_rd  = '0;
    for (int w = 0; w < WAYS; w++) begin
      tag_rd[w*TAG_W +: TAG_W] = tags[snp_idx][w];
      st_rd[2*w +: 2]          = sts[snp_idx][w];
    end
    data_rd = word_of(int'(rd_way), int'(snp_idx), int'(rd_off));
  end

  int errors = 0;
  int checks = 0;
  logic [3:0]  exp_upd  [$];
  logic [31:0] exp_word [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: pop an expectation whenever the DUT emits an update or a flush word.
  always @(negedge CLK) begin
    if (!RST && upd_en) begin
      if (exp_upd.size() == 0) chk("upd_unexpected", 32'(upd_en), 32'd0);
      else chk("upd_way_state", 32'({upd_way, upd_state}), 32'(exp_upd.pop_front()));
    end
    if (!RST && !dwait && dstore !== 32'd0) begin
      if (exp_word.size() == 0) chk("word_unexpected", dstore, 32'd0);
      else chk("flush_word", dstore, exp_word.pop_front());
    end
  end

  initial begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 4; w++) begin
        tags[s][w] = '0;
        sts[s][w]  = 2'b00;
      end
    tags[2][0] = 26'h55;  sts[2][0] = 2'b01;
    tags[2][1] = 26'h66;  sts[2][1] = 2'b10;
    tags[5][0] = 26'hABC; sts[5][0] = 2'b01;
    tags[5][1] = 26'hABC; sts[5][1] = 2'b10;
    tags[3][1] = 26'h1234; sts[3][1] = 2'b10;
    tags[6][0] = 26'h777; sts[6][0] = 2'b00;
    tags[6][1] = 26'h777; sts[6][1] = 2'b10;

    RST = 1'b1; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = '0;
    cyc(); cyc();
    chk("rst_ccwrite", 32'(ccwrite), 32'd0);
    chk("rst_upd_en", 32'(upd_en), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_rd_way_off", 32'({rd_way, rd_off}), 32'd0);
    chk("rst_snp_idx", 32'(snp_idx), 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    RST = 1'b0;
    cyc();

    // Miss in set 2
    ccwait = 1'b1; ccsnoopaddr = mk_addr(26'h77, 3'd2, 1'b1);
    cyc();
    chk("miss_snp_idx", 32'(snp_idx), 32'd2);
    cyc();
    chk("miss_ccwrite", 32'(ccwrite), 32'd0);
    cyc(); cyc();
    chk("miss_upd_en", 32'(upd_en), 32'd0);
    chk("miss_hold_done", 32'(cpu_hold), 32'd1);
    ccwait = 1'b0;
    cyc();
    chk("miss_hold_idle", 32'(cpu_hold), 32'd0);
    cyc();

    // S hit with invalidate; way 0 wins over matching M way 1
    exp_upd.push_back({2'd0, 2'b00});
    ccwait = 1'b1; ccinv = 1'b1; ccsnoopaddr = mk_addr(26'hABC, 3'd5, 1'b0);
    cyc(); cyc();
    chk("shit_ccwrite", 32'(ccwrite), 32'd0);
    chk("shit_dstore", dstore, 32'd0);
    cyc(); cyc(); cyc();
    ccwait = 1'b0; ccinv = 1'b0;
    cyc();
    chk("shit_upd_done", 32'(exp_upd.size()), 32'd0);
    chk("shit_hold", 32'(cpu_hold), 32'd0);

    // M hit, flush both words without stall, downgrade to S
    exp_word.push_back(word_of(1, 3, 0));
    exp_word.push_back(word_of(1, 3, 1));
    exp_upd.push_back({2'd1, 2'b01});
    ccwait = 1'b1; ccsnoopaddr = mk_addr(26'h1234, 3'd3, 1'b1);
    cyc(); cyc();
    chk("mhit_ccwrite_c2", 32'(ccwrite), 32'd1);
    chk("mhit_rd_way", 32'(rd_way), 32'd1);
    cyc();
    chk("mhit_off0", 32'(rd_off), 32'd0);
    chk("mhit_dstore0", dstore, word_of(1, 3, 0));
    dwait = 1'b0;
    cyc();
    chk("mhit_off1", 32'(rd_off), 32'd1);
    chk("mhit_dstore1", dstore, word_of(1, 3, 1));
    cyc();
    dwait = 1'b1;
    chk("mhit_ccwrite_upd", 32'(ccwrite), 32'd1);
    cyc(); cyc();
    chk("mhit_ccwrite_done", 32'(ccwrite), 32'd1);
    ccwait = 1'b0;
    cyc();
    chk("mhit_ccwrite_idle", 32'(ccwrite), 32'd0);
    chk("mhit_queues", 32'(exp_word.size() + exp_upd.size()), 32'd0);

    // M hit in way 1 (way 0 tag matches but invalid), 5-cycle stall, inv during UPDATE
    exp_word.push_back(word_of(1, 6, 0));
    exp_word.push_back(word_of(1, 6, 1));
    exp_upd.push_back({2'd1, 2'b00});
    ccwait = 1'b1; ccsnoopaddr = mk_addr(26'h777, 3'd6, 1'b0);
    cyc(); cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_dstore", dstore, word_of(1, 6, 0));
      chk("stall_off", 32'(rd_off), 32'd0);
      cyc();
    end
    dwait = 1'b0;
    cyc();
    chk("stall_off1", 32'(rd_off), 32'd1);
    cyc();
    dwait = 1'b1; ccinv = 1'b1;
    cyc();
    ccinv = 1'b0;
    cyc();
    ccwait = 1'b0;
    cyc();
    chk("stall_queues", 32'(exp_word.size() + exp_upd.size()), 32'd0);

    // Abort in FLUSH after word 0
    exp_word.push_back(word_of(1, 3, 0));
    ccwait = 1'b1; ccsnoopaddr = mk_addr(26'h1234, 3'd3, 1'b0);
    cyc(); cyc(); cyc();
    dwait = 1'b0;
    cyc();
    ccwait = 1'b0; dwait = 1'b1;
    #1;
    chk("abort_hold_flush", 32'(cpu_hold), 32'd1);
    cyc();
    chk("abort_hold_idle", 32'(cpu_hold), 32'd0);
    chk("abort_ccwrite", 32'(ccwrite), 32'd0);
    cyc(); cyc(); cyc();
    chk("abort_queues", 32'(exp_word.size() + exp_upd.size()), 32'd0);

`ifdef SNOOP_STATS_EN
    chk("stats_hits", 32'(snp_hits), 32'd4);
    chk("stats_flushes", 32'(snp_flushes), 32'd2);
`endif

    // Reset mid-FLUSH
    ccwait = 1'b1; ccsnoopaddr = mk_addr(26'h1234, 3'd3, 1'b0);
    cyc(); cyc(); cyc();
    chk("rstf_dstore_active", dstore, word_of(1, 3, 0));
    RST = 1'b1; ccwait = 1'b0;
    cyc();
    chk("rstf_ccwrite", 32'(ccwrite), 32'd0);
    chk("rstf_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rstf_dstore", dstore, 32'd0);
    chk("rstf_rd", 32'({snp_idx, rd_way, rd_off}), 32'd0);
    chk("rstf_upd", 32'({upd_en, upd_way, upd_state}), 32'd0);
`ifdef SNOOP_STATS_EN
    chk("rstf_stats", 32'({snp_hits, snp_flushes}), 32'd0);
`endif
    RST = 1'b0;
    cyc(); cyc(); cyc();
    chk("final_queues", 32'(exp_word.size() + exp_upd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
